// File: rtl/tdc_pulse_gen.sv
// rtl/tdc_pulse_gen.sv - push-button driven start/stop pulse generator for TDC bench tests
// Two debounced buttons fire shots or bursts and step the delay setting; stops are staggered per channel.
module tdc_pulse_gen #(
    parameter int CHANNELS   = 4,
    parameter int DW         = 16,
    parameter int BASE_DLY   = 10,
    parameter int STEP_DLY   = 5,
    parameter int CH_SPACING = 3,
    parameter int PULSE_W    = 2,
    parameter int NSTEPS     = 8,
    parameter int BURST      = 1,
    parameter int GAP_CYC    = 8,
    parameter int DEB_CYC    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw1,
    input  logic                sw2,
    output logic                teststart,
    output logic [CHANNELS-1:0] teststop,
    output logic [6:0]          led
);
    localparam int IW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam longint MAX_END = longint'(BASE_DLY) + longint'(NSTEPS - 1) * STEP_DLY
                               + longint'(CHANNELS - 1) * CH_SPACING + PULSE_W;

    if ((MAX_END >> DW) != 0 || (longint'(GAP_CYC) >> DW) != 0) begin : g_dw_too_small
        $error("tdc_pulse_gen: DW too narrow for longest delay plus pulse width");
    end
    if (CHANNELS < 1 || CHANNELS > 8 || BURST < 1 || BURST > 255 || BASE_DLY < 1 ||
        PULSE_W < 1 || GAP_CYC < 1 || NSTEPS < 1 || DEB_CYC < 1) begin : g_bad_param
        $error("tdc_pulse_gen: parameter out of range");
    end

    // Bit 0 is sw1 (fire), bit 1 is sw2 (step); both buttons are active-low.
    logic [1:0]         sync1_q, sync2_q, deb_q, deb_d, press;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            deb_q   <= 2'b11;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {sw2, sw1};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CW'(DEB_CYC - 1)) deb_d[b] = sync2_q[b];
                else                              cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
        press = deb_q & ~deb_d;
    end

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       t_q, t_d;
    logic [IW-1:0]       idx_q, idx_d, act_q, act_d;
    logic [7:0]          left_q, left_d;
    logic [2:0]          shots_q, shots_d;
    logic                start_d;
    logic [CHANNELS-1:0] stop_d;
    logic [DW-1:0]       base_d, dk, last_t;

    assign last_t = DW'(BASE_DLY) + DW'(act_q) * DW'(STEP_DLY)
                  + DW'((CHANNELS - 1) * CH_SPACING + PULSE_W - 1);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        act_d   = act_q;
        left_d  = left_q;
        shots_d = shots_q;
        if (press[1]) idx_d = (idx_q == IW'(NSTEPS - 1)) ? '0 : idx_q + 1'b1;
        unique case (state_q)
            IDLE: if (press[0]) begin
                state_d = RUN;
                t_d     = '0;
                act_d   = idx_q;
                left_d  = 8'(BURST - 1);
            end
            RUN: if (t_q == last_t) begin
                state_d = GAP;
                t_d     = '0;
                shots_d = shots_q + 1'b1;
            end else begin
                t_d = t_q + 1'b1;
            end
            GAP: if (t_q == DW'(GAP_CYC - 1)) begin
                t_d = '0;
                if (left_q != 8'd0) begin
                    state_d = RUN;
                    act_d   = idx_q;
                    left_d  = left_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                t_d = t_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next-state values so the registered pulses line up with t.
        base_d  = DW'(BASE_DLY) + DW'(act_d) * DW'(STEP_DLY);
        start_d = (state_d == RUN) && (t_d < DW'(PULSE_W));
        stop_d  = '0;
        dk      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            dk        = base_d + DW'(k * CH_SPACING);
            stop_d[k] = (state_d == RUN) && (t_d >= dk) && (t_d < dk + DW'(PULSE_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            t_q       <= '0;
            idx_q     <= '0;
            act_q     <= '0;
            left_q    <= '0;
            shots_q   <= '0;
            teststart <= 1'b0;
            teststop  <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            left_q    <= left_d;
            shots_q   <= shots_d;
            teststart <= start_d;
            teststop  <= stop_d;
        end
    end

    assign led = {state_q != IDLE, shots_q, 3'(idx_q)};
endmodule

// File: tb/tb_tdc_pulse_gen.sv
// tb/tb_tdc_pulse_gen.sv - scoreboard bench for tdc_pulse_gen
`timescale 1ns/1ps
module tb_tdc_pulse_gen;
    localparam int CH = 4, BASE = 10, STEP = 5, SP = 3, PW = 2, NST = 8, GAP = 8, DEB = 4;
    localparam int SHOT0 = BASE + (CH - 1) * SP + PW;

    typedef struct packed { int ch; int off; int w; } ev_t;

    logic clk = 0, rst = 0, sw1 = 1, sw2 = 1, sw1b = 1, sw2b = 1;
    logic teststart, start_b;
    logic [CH-1:0] teststop, stop_b;
    logic [6:0] led, led_b;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int m_idx = 0, m_shots = 0, last_start = 0, bbusy_fall = 0;
    ev_t exp_q[$], obs_q[$];
    int bstart_q[$], boff_q[$];
    int rise [0:CH];
    logic [CH:0] pv = '0, v;
    logic pb_start = 0, pb_stop = 0, pb_busy = 0;
    ev_t ev_m;

    always #5 clk = ~clk;

    tdc_pulse_gen #(.CHANNELS(CH), .DW(16), .BASE_DLY(BASE), .STEP_DLY(STEP), .CH_SPACING(SP),
                    .PULSE_W(PW), .NSTEPS(NST), .BURST(1), .GAP_CYC(GAP), .DEB_CYC(DEB)) u_dut (
        .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2),
        .teststart(teststart), .teststop(teststop), .led(led));

    tdc_pulse_gen #(.CHANNELS(CH), .DW(16), .BASE_DLY(BASE), .STEP_DLY(STEP), .CH_SPACING(SP),
                    .PULSE_W(PW), .NSTEPS(NST), .BURST(3), .GAP_CYC(GAP), .DEB_CYC(DEB)) u_burst (
        .clk(clk), .rst(rst), .sw1(sw1b), .sw2(sw2b),
        .teststart(start_b), .teststop(stop_b), .led(led_b));

    // Monitor: every completed pulse becomes {channel, rise offset from teststart rise, width}.
    always @(negedge clk) begin
        cyc++;
        v = {teststop, teststart};
        for (int c = 0; c <= CH; c++) begin
            if (v[c] && !pv[c]) begin
                rise[c] = cyc;
                if (c == 0) last_start = cyc;
            end
            if (!v[c] && pv[c]) begin
                ev_m.ch = c; ev_m.off = rise[c] - last_start; ev_m.w = cyc - rise[c];
                obs_q.push_back(ev_m);
            end
        end
        pv = v;
        if (start_b && !pb_start) bstart_q.push_back(cyc);
        if (stop_b[CH-1] && !pb_stop)
            boff_q.push_back((bstart_q.size() > 0) ? cyc - bstart_q[bstart_q.size()-1] : -1);
        if (!led_b[6] && pb_busy) bbusy_fall = cyc;
        pb_start = start_b; pb_stop = stop_b[CH-1]; pb_busy = led_b[6];
    end

    function automatic void push_shot(input int idx);
        ev_t e;
        e.ch = 0; e.off = 0; e.w = PW;
        exp_q.push_back(e);
        for (int k = 0; k < CH; k++) begin
            e.ch = k + 1; e.off = BASE + idx * STEP + k * SP; e.w = PW;
            exp_q.push_back(e);
        end
    endfunction

    task automatic press_btn(input int which, input int low_cyc);
        @(posedge clk); #1;
        case (which)
            1: sw1 = 0;
            2: sw2 = 0;
            default: sw1b = 0;
        endcase
        repeat (low_cyc) @(posedge clk);
        #1; sw1 = 1; sw2 = 1; sw1b = 1;
    endtask

    task automatic wait_idle(input bit burst_dut, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!(burst_dut ? led_b[6] : led[6])) begin ok = 1; break; end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (teststart) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        n_tests++; if (teststart !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, required 0", teststart); end
        n_tests++; if (teststop !== '0) begin n_fail++; $display("FAIL reset_stop: got %b, required 0", teststop); end
        n_tests++; if (led !== 7'd0) begin n_fail++; $display("FAIL reset_led: got %b, required 0", led); end
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        n_tests++; if (led_b !== 7'd0) begin n_fail++; $display("FAIL reset_led_burst: got %b, required 0", led_b); end
    endtask

    task automatic test_single_shot();
        bit ok; ev_t e, o;
        obs_q.delete();
        push_shot(m_idx);
        press_btn(1, 20);
        wait_idle(0, 200, ok);
        repeat (5) @(negedge clk);
        m_shots++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: busy stuck 1, required 0"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o.ch = -1; o.off = -1; o.w = -1; end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL single_pulse: got ch%0d off %0d w %0d, required ch%0d off %0d w %0d", o.ch, o.off, o.w, e.ch, e.off, e.w); end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra pulses, required 0", obs_q.size()); end
        n_tests++; if (led !== {1'b0, 3'(m_shots), 3'(m_idx)}) begin n_fail++; $display("FAIL single_led: got %b, required %b", led, {1'b0, 3'(m_shots), 3'(m_idx)}); end
    endtask

    task automatic test_step();
        bit ok; ev_t e, o;
        for (int i = 0; i < 3; i++) begin press_btn(2, 12); repeat (12) @(posedge clk); m_idx++; end
        @(negedge clk);
        n_tests++; if (led[2:0] !== 3'(m_idx)) begin n_fail++; $display("FAIL step_idx3: got %0d, required %0d", led[2:0], m_idx); end
        obs_q.delete();
        push_shot(m_idx);
        press_btn(1, 20);
        wait_idle(0, 300, ok);
        repeat (5) @(negedge clk);
        m_shots++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL step_timeout: busy stuck 1, required 0"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o.ch = -1; o.off = -1; o.w = -1; end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL step_pulse: got ch%0d off %0d w %0d, required ch%0d off %0d w %0d", o.ch, o.off, o.w, e.ch, e.off, e.w); end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL step_extra: got %0d extra pulses, required 0", obs_q.size()); end
        for (int i = 0; i < 5; i++) begin press_btn(2, 12); repeat (12) @(posedge clk); m_idx = (m_idx + 1) % NST; end
        @(negedge clk);
        n_tests++; if (led[2:0] !== 3'(m_idx)) begin n_fail++; $display("FAIL step_wrap: got %0d, required %0d", led[2:0], m_idx); end
    endtask

    task automatic test_glitch();
        bit ok; ev_t e, o;
        obs_q.delete();
        press_btn(1, 2);
        repeat (40) @(negedge clk);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d pulses, required 0", obs_q.size()); end
        n_tests++; if (led !== {1'b0, 3'(m_shots), 3'(m_idx)}) begin n_fail++; $display("FAIL glitch_led: got %b, required %b", led, {1'b0, 3'(m_shots), 3'(m_idx)}); end
        push_shot(m_idx);
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1 sw1 = ~sw1; end
        press_btn(1, 20);
        wait_idle(0, 200, ok);
        repeat (5) @(negedge clk);
        m_shots++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bounce_timeout: busy stuck 1, required 0"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o.ch = -1; o.off = -1; o.w = -1; end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL bounce_pulse: got ch%0d off %0d w %0d, required ch%0d off %0d w %0d", o.ch, o.off, o.w, e.ch, e.off, e.w); end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bounce_extra: got %0d extra pulses, required 0", obs_q.size()); end
    endtask

    task automatic test_busy_midstep();
        bit ok; ev_t e, o;
        obs_q.delete();
        push_shot(m_idx);
        @(posedge clk); #1 sw1 = 0;
        wait_start(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout: teststart 0, required 1"); end
        sw1 = 1;
        repeat (5) @(posedge clk); #1 sw2 = 0;
        repeat (3) @(posedge clk); #1 sw1 = 0;
        repeat (12) @(posedge clk); #1 sw1 = 1; sw2 = 1;
        m_idx = (m_idx + 1) % NST;
        wait_idle(0, 200, ok);
        repeat (40) @(negedge clk);
        m_shots++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: busy stuck 1, required 0"); end
        push_shot(m_idx);
        press_btn(1, 20);
        wait_idle(0, 200, ok);
        repeat (5) @(negedge clk);
        m_shots++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o.ch = -1; o.off = -1; o.w = -1; end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL busy_pulse: got ch%0d off %0d w %0d, required ch%0d off %0d w %0d", o.ch, o.off, o.w, e.ch, e.off, e.w); end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL busy_extra: got %0d extra pulses, required 0", obs_q.size()); end
        n_tests++; if (led !== {1'b0, 3'(m_shots), 3'(m_idx)}) begin n_fail++; $display("FAIL busy_led: got %b, required %b", led, {1'b0, 3'(m_shots), 3'(m_idx)}); end
    endtask

    task automatic test_reset_midshot();
        bit ok; ev_t e, o;
        obs_q.delete();
        @(posedge clk); #1 sw1 = 0;
        wait_start(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_start_timeout: teststart 0, required 1"); end
        sw1 = 1;
        repeat (BASE + m_idx * STEP + SP) @(posedge clk);
        #2;
        n_tests++; if (teststop[1] !== 1'b1) begin n_fail++; $display("FAIL rstmid_stop1_before: got %b, required 1", teststop[1]); end
        #1 rst = 1;
        #1;
        n_tests++; if (teststart !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b, required 0", teststart); end
        n_tests++; if (teststop !== '0) begin n_fail++; $display("FAIL rstmid_stop: got %b, required 0", teststop); end
        n_tests++; if (led !== 7'd0) begin n_fail++; $display("FAIL rstmid_led: got %b, required 0", led); end
        @(negedge clk); rst = 0;
        m_idx = 0; m_shots = 0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        n_tests++; if (led !== 7'd0) begin n_fail++; $display("FAIL rstmid_led_after: got %b, required 0", led); end
        push_shot(m_idx);
        press_btn(1, 20);
        wait_idle(0, 200, ok);
        repeat (5) @(negedge clk);
        m_shots++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else begin o.ch = -1; o.off = -1; o.w = -1; end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rstmid_pulse: got ch%0d off %0d w %0d, required ch%0d off %0d w %0d", o.ch, o.off, o.w, e.ch, e.off, e.w); end
        end
        n_tests++; if (led !== {1'b0, 3'(m_shots), 3'(m_idx)}) begin n_fail++; $display("FAIL rstmid_led_shot: got %b, required %b", led, {1'b0, 3'(m_shots), 3'(m_idx)}); end
    endtask

    task automatic test_burst();
        bit ok;
        int exp_off, per;
        bstart_q.delete(); boff_q.delete();
        press_btn(3, 20);
        wait_idle(1, 400, ok);
        repeat (5) @(negedge clk);
        exp_off = BASE + (CH - 1) * SP;
        per = SHOT0 + GAP;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL burst_timeout: busy stuck 1, required 0"); end
        n_tests++; if (bstart_q.size() != 3) begin n_fail++; $display("FAIL burst_count: got %0d shots, required 3", bstart_q.size()); end
        for (int i = 1; i < bstart_q.size(); i++) begin
            n_tests++;
            if (bstart_q[i] - bstart_q[i-1] != per) begin n_fail++; $display("FAIL burst_period: got %0d, required %0d", bstart_q[i] - bstart_q[i-1], per); end
        end
        n_tests++; if (boff_q.size() != 3) begin n_fail++; $display("FAIL burst_stops: got %0d last-channel stops, required 3", boff_q.size()); end
        while (boff_q.size() != 0) begin
            n_tests++;
            if (boff_q[0] != exp_off) begin n_fail++; $display("FAIL burst_stop_off: got %0d, required %0d", boff_q[0], exp_off); end
            void'(boff_q.pop_front());
        end
        n_tests++; if (led_b[5:3] !== 3'd3) begin n_fail++; $display("FAIL burst_shots: got %0d, required 3", led_b[5:3]); end
        if (bstart_q.size() != 0) begin
            n_tests++;
            if (bbusy_fall - bstart_q[bstart_q.size()-1] != per) begin n_fail++; $display("FAIL burst_busy_fall: got %0d, required %0d", bbusy_fall - bstart_q[bstart_q.size()-1], per); end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_step();
        test_glitch();
        test_busy_midstep();
        test_reset_midshot();
        test_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
